row_frame_fetch: RTL

// - Upstream feeder for the TLC5941 pixel driver: fetches one scan row of 12-bit grayscale words

---
 rtl/row_frame_fetch.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/row_frame_fetch.sv
// Row fetcher for the TLC5941 driver: fills a double-buffered 576-bit row image from pixel RAM.
// Optional ROW_BRIGHTNESS_EN scales each captured GS word by (brightness+1)/16.
module row_frame_fetch #(
  parameter int ROWS    = 8,
  parameter int WORDS   = 48,
  parameter int GS_BITS = 12,
  parameter int ADDR_W  = 9
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic               mem_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [GS_BITS-1:0] mem_rdata,
  input  logic [9:0]         bit_index,
  output logic               row_bit,
  input  logic               row_latch,
  input  logic               frame_start,
  output logic [2:0]         row_sel,
  output logic               row_ready,
  output logic               underrun,
  input  logic [3:0]         brightness
);

  localparam int ROW_W = WORDS * GS_BITS;
  localparam int CNT_W = $clog2(WORDS + 2);
`ifdef ROW_BRIGHTNESS_EN
  localparam int FETCH_LAST = WORDS + 1;
`else
  localparam int FETCH_LAST = WORDS;
`endif

  typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         fetch_row;
  logic               front_valid;
  logic               front_sel;
  logic               swap;
  logic [ADDR_W-1:0]  row_base;
  logic [ROW_W-1:0]   buf_a, buf_b;
  logic [ROW_W-1:0]   front_row;
  logic               vld_p0;
  logic [CNT_W-1:0]   idx_p0;
  logic               wr_en;
  logic [CNT_W-1:0]   wr_idx;
  logic [GS_BITS-1:0] wr_data;

`ifdef ROW_BRIGHTNESS_EN
  logic               vld_p1;
  logic [CNT_W-1:0]   idx_p1;
  logic [GS_BITS-1:0] data_p1;

  function automatic logic [GS_BITS-1:0] scale_gs(input logic [GS_BITS-1:0] w,
                                                  input logic [3:0] b);
    logic [15:0] prod;
    prod = 16'(w) * 16'({1'b0, b} + 5'd1);
    return GS_BITS'(prod >> 4);
  endfunction
`else
  logic brightness_unused;
  assign brightness_unused = ^brightness;
`endif

  // A swap happens on the first full row after a restart, or on the driver's latch.
  assign swap = (state == FULL) && !frame_start && (!front_valid || row_latch);

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (cnt == CNT_W'(FETCH_LAST)) state_nxt = FULL;
      FULL:    if (swap) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
    if (frame_start) state_nxt = IDLE;
  end

  always_comb begin
    row_base  = ADDR_W'(fetch_row) * ADDR_W'(WORDS);
    mem_en    = (state == FETCH) && (cnt < CNT_W'(WORDS));
    mem_addr  = row_base + ADDR_W'(cnt);
    row_ready = (state == FULL);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt         <= '0;
      fetch_row   <= '0;
      row_sel     <= '0;
      front_valid <= 1'b0;
      front_sel   <= 1'b0;
      underrun    <= 1'b0;
      vld_p0      <= 1'b0;
`ifdef ROW_BRIGHTNESS_EN
      vld_p1      <= 1'b0;
`endif
    end else begin
      cnt    <= (state == FETCH && state_nxt == FETCH) ? cnt + 1'b1 : '0;
      vld_p0 <= mem_en && !frame_start;
`ifdef ROW_BRIGHTNESS_EN
      vld_p1 <= vld_p0 && !frame_start;
`endif
      if (frame_start) begin
        fetch_row   <= '0;
        front_valid <= 1'b0;
      end else if (swap) begin
        front_sel   <= ~front_sel;
        front_valid <= 1'b1;
        row_sel     <= fetch_row;
        fetch_row   <= (fetch_row == 3'(ROWS - 1)) ? 3'd0 : fetch_row + 3'd1;
      end
      if (row_latch && front_valid && state != FULL && !frame_start)
        underrun <= 1'b1;
    end
  end

  // p0: RAM read returns; index travels with the request.
  always_ff @(posedge clock) begin
    idx_p0 <= cnt;
`ifdef ROW_BRIGHTNESS_EN
    // p1: scaled word ready for the back buffer.
    idx_p1  <= idx_p0;
    data_p1 <= scale_gs(mem_rdata, brightness);
`endif
  end

`ifdef ROW_BRIGHTNESS_EN
  assign wr_en   = vld_p1 && !frame_start;
  assign wr_idx  = idx_p1;
  assign wr_data = data_p1;
`else
  assign wr_en   = vld_p0 && !frame_start;
  assign wr_idx  = idx_p0;
  assign wr_data = mem_rdata;
`endif

  always_ff @(posedge clock) begin
    if (wr_en) begin
      if (front_sel) buf_a[wr_idx * GS_BITS +: GS_BITS] <= wr_data;
      else           buf_b[wr_idx * GS_BITS +: GS_BITS] <= wr_data;
    end
  end

  always_comb begin
    front_row = front_sel ? buf_b : buf_a;
    row_bit   = front_valid && (bit_index < 10'(ROW_W)) && front_row[bit_index];
  end

endmodule
